// File: rtl/display_pkg.sv
// Shared definitions for the framebuffer controller: pixel width, bank-relative
// RAM addressing and controller state encoding.
package display_pkg;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } fb_state_t;

    function automatic int unsigned pix_width(input int unsigned bitwidth);
        return 3 * bitwidth;
    endfunction

    // Bank 1 occupies the upper half of the RAM, rows are laid out back to back.
    function automatic int unsigned fb_addr(
        input logic        bank,
        input int unsigned r,
        input int unsigned c,
        input int unsigned rows,
        input int unsigned columns
    );
        return (bank ? rows * columns : 0) + r * columns + c;
    endfunction

endpackage

// File: rtl/framebuffer_ram.sv
// Single-port pixel RAM holding both banks; synchronous read with one cycle of
// latency. The read register only updates on a read, so it holds between fetches.
module framebuffer_ram #(
    parameter int unsigned depth = 512,
    parameter int unsigned width = 24,
    parameter int unsigned aw    = 9
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_we,
    input  logic             i_re,
    input  logic [aw-1:0]    i_addr,
    input  logic [width-1:0] i_wdata,
    output logic [width-1:0] o_rdata
);

    logic [width-1:0] r_mem [depth];
    logic [width-1:0] r_rdata;

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_addr] <= i_wdata;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_rdata <= '0;
        end else if (i_re) begin
            r_rdata <= r_mem[i_addr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/framebuffer_controller.sv
// Double-buffered framebuffer: driver fetches from the front bank, host writes
// and bulk clears target the back bank, banks swap only on a frame boundary.
module framebuffer_controller
    import display_pkg::*;
#(
    parameter int unsigned rows     = 8,
    parameter int unsigned columns  = 32,
    parameter int unsigned bitwidth = 8
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               frame_complete,
    input  logic                               rd_en,
    input  logic [$clog2(rows)-1:0]            row,
    input  logic [$clog2(columns)-1:0]         column,
    output logic [pix_width(bitwidth)-1:0]     pixel,
    output logic                               pixel_valid,
    input  logic                               wr_valid,
    output logic                               wr_ready,
    input  logic [$clog2(rows)-1:0]            wr_row,
    input  logic [$clog2(columns)-1:0]         wr_column,
    input  logic [pix_width(bitwidth)-1:0]     wr_pixel,
    input  logic                               swap_req,
    output logic                               swap_pending,
    output logic                               swap_done,
    input  logic                               clear_req,
    input  logic [pix_width(bitwidth)-1:0]     clear_pixel,
    output logic                               busy
);

    localparam int unsigned PW   = pix_width(bitwidth);
    localparam int unsigned NPIX = rows * columns;
    localparam int unsigned AW   = $clog2(2 * NPIX);
    localparam int unsigned NW   = $clog2(NPIX);

    fb_state_t       r_state;
    fb_state_t       w_state_nxt;
    logic [NW-1:0]   r_cnt;
    logic [NW-1:0]   w_cnt_nxt;
    logic [PW-1:0]   r_clr_pix;
    logic            r_front_bank;
    logic            r_swap_pending;
    logic            r_swap_done;
    logic            r_pixel_valid;

    logic            w_clr_we;
    logic            w_host_hs;
    logic            w_host_we;
    logic            w_in_range;
    logic            w_swap_fire;
    logic            w_ram_we;
    logic            w_ram_re;
    logic [AW-1:0]   w_ram_addr;
    logic [PW-1:0]   w_ram_wdata;
    logic [PW-1:0]   w_ram_rdata;

    assign wr_ready    = (r_state == ST_IDLE) && !rd_en && !clear_req && !rst;
    assign w_host_hs   = wr_valid && wr_ready;
    assign w_in_range  = (32'(wr_row) < rows) && (32'(wr_column) < columns);
    assign w_host_we   = w_host_hs && w_in_range;
    assign w_clr_we    = (r_state == ST_CLEAR) && !rd_en && !rst;
    assign w_swap_fire = frame_complete && r_swap_pending && (r_state == ST_IDLE);
    assign w_ram_re    = rd_en && !rst;

    // Fixed priority: driver fetch, then clear fill, then host write.
    always_comb begin
        w_ram_addr  = '0;
        w_ram_we    = 1'b0;
        w_ram_wdata = '0;
        if (rd_en) begin
            w_ram_addr = AW'(fb_addr(r_front_bank, 32'(row), 32'(column), rows, columns));
        end else if (w_clr_we) begin
            w_ram_addr  = AW'(fb_addr(!r_front_bank, 0, 32'(r_cnt), rows, columns));
            w_ram_we    = 1'b1;
            w_ram_wdata = r_clr_pix;
        end else if (w_host_we) begin
            w_ram_addr  = AW'(fb_addr(!r_front_bank, 32'(wr_row), 32'(wr_column), rows, columns));
            w_ram_we    = 1'b1;
            w_ram_wdata = wr_pixel;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            ST_IDLE: begin
                if (clear_req) begin
                    w_state_nxt = ST_CLEAR;
                    w_cnt_nxt   = '0;
                end
            end
            ST_CLEAR: begin
                if (!rd_en) begin
                    w_cnt_nxt = r_cnt + 1'b1;
                    if (r_cnt == NW'(NPIX - 1)) begin
                        w_state_nxt = ST_IDLE;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= ST_IDLE;
            r_cnt          <= '0;
            r_front_bank   <= 1'b0;
            r_swap_pending <= 1'b0;
            r_swap_done    <= 1'b0;
            r_pixel_valid  <= 1'b0;
        end else begin
            r_state        <= w_state_nxt;
            r_cnt          <= w_cnt_nxt;
            r_front_bank   <= r_front_bank ^ w_swap_fire;
            // A request arriving on the swap edge itself is consumed by that swap.
            r_swap_pending <= w_swap_fire ? 1'b0 : (r_swap_pending | swap_req);
            r_swap_done    <= w_swap_fire;
            r_pixel_valid  <= rd_en;
        end
    end

    always_ff @(posedge clk) begin
        if ((r_state == ST_IDLE) && clear_req) begin
            r_clr_pix <= clear_pixel;
        end
    end

    framebuffer_ram #(
        .depth (2 * NPIX),
        .width (PW),
        .aw    (AW)
    ) u_ram (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_we    (w_ram_we),
        .i_re    (w_ram_re),
        .i_addr  (w_ram_addr),
        .i_wdata (w_ram_wdata),
        .o_rdata (w_ram_rdata)
    );

    assign pixel        = w_ram_rdata;
    assign pixel_valid  = r_pixel_valid;
    assign swap_pending = r_swap_pending;
    assign swap_done    = r_swap_done;
    assign busy         = (r_state == ST_CLEAR);

endmodule

// File: tb/tb_framebuffer_controller.sv
// Directed bench for framebuffer_controller: clear/swap sequences, a vector table
// for read/write/swap interplay, reset mid-clear and out-of-range host writes.
module tb_framebuffer_controller;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, frame_complete, rd_en, pixel_valid, wr_valid, wr_ready;
    logic [2:0]  row, wr_row;
    logic [4:0]  column, wr_column;
    logic [23:0] pixel, wr_pixel, clear_pixel;
    logic        swap_req, swap_pending, swap_done, clear_req, busy;

    framebuffer_controller #(.rows(8), .columns(32), .bitwidth(8)) dut (
        .clk(clk), .rst(rst), .frame_complete(frame_complete), .rd_en(rd_en),
        .row(row), .column(column), .pixel(pixel), .pixel_valid(pixel_valid),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_row(wr_row), .wr_column(wr_column),
        .wr_pixel(wr_pixel), .swap_req(swap_req), .swap_pending(swap_pending),
        .swap_done(swap_done), .clear_req(clear_req), .clear_pixel(clear_pixel), .busy(busy)
    );

    // 6x6 instance so that out-of-range coordinates are representable
    logic        s_fc, s_rd, s_pv, s_wv, s_wready, s_sreq, s_pend, s_done, s_creq, s_busy;
    logic [2:0]  s_row, s_col, s_wrow, s_wcol;
    logic [23:0] s_pixel, s_wpix, s_cpix;

    framebuffer_controller #(.rows(6), .columns(6), .bitwidth(8)) dut_s (
        .clk(clk), .rst(rst), .frame_complete(s_fc), .rd_en(s_rd),
        .row(s_row), .column(s_col), .pixel(s_pixel), .pixel_valid(s_pv),
        .wr_valid(s_wv), .wr_ready(s_wready), .wr_row(s_wrow), .wr_column(s_wcol),
        .wr_pixel(s_wpix), .swap_req(s_sreq), .swap_pending(s_pend),
        .swap_done(s_done), .clear_req(s_creq), .clear_pixel(s_cpix), .busy(s_busy)
    );

    typedef struct {
        logic        rd;
        logic [2:0]  row;
        logic [4:0]  col;
        logic        wv;
        logic [2:0]  wrow;
        logic [4:0]  wcol;
        logic [23:0] wpix;
        logic        sreq;
        logic        fc;
        logic        e_ready;
        logic        e_pv;
        logic [23:0] e_pix;
        logic        e_pend;
        logic        e_done;
    } vec_t;

    vec_t tbl [18];
    int   n_vec = 0;
    int   n_err = 0;
    int   cnt;
    logic saw_done;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b, expected %b", name, act, exp);
        end
    endtask

    task automatic chk24(input string name, input logic [23:0] act, input logic [23:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic chkn(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic idle();
        frame_complete = 1'b0; rd_en = 1'b0; row = '0; column = '0;
        wr_valid = 1'b0; wr_row = '0; wr_column = '0; wr_pixel = '0;
        swap_req = 1'b0; clear_req = 1'b0; clear_pixel = '0;
    endtask

    task automatic s_idle();
        s_fc = 1'b0; s_rd = 1'b0; s_row = '0; s_col = '0;
        s_wv = 1'b0; s_wrow = '0; s_wcol = '0; s_wpix = '0;
        s_sreq = 1'b0; s_creq = 1'b0; s_cpix = '0;
    endtask

    initial begin
        // rd row col  wv wrow wcol wpix  sreq fc | ready pv pix pend done
        tbl[0]  = '{1'b0, 3'd0, 5'd0,  1'b1, 3'd3, 5'd5,  24'h123456, 1'b0, 1'b0, 1'b1, 1'b0, 24'h0000aa, 1'b0, 1'b0};
        tbl[1]  = '{1'b1, 3'd3, 5'd5,  1'b0, 3'd0, 5'd0,  24'h000000, 1'b0, 1'b0, 1'b0, 1'b1, 24'h0000aa, 1'b0, 1'b0};
        tbl[2]  = '{1'b0, 3'd0, 5'd0,  1'b0, 3'd0, 5'd0,  24'h000000, 1'b1, 1'b0, 1'b1, 1'b0, 24'h0000aa, 1'b1, 1'b0};
        tbl[3]  = '{1'b1, 3'd3, 5'd5,  1'b1, 3'd3, 5'd6,  24'habcdef, 1'b0, 1'b0, 1'b0, 1'b1, 24'h0000aa, 1'b1, 1'b0};
        tbl[4]  = '{1'b0, 3'd0, 5'd0,  1'b0, 3'd0, 5'd0,  24'h000000, 1'b0, 1'b0, 1'b1, 1'b0, 24'h0000aa, 1'b1, 1'b0};
        tbl[5]  = '{1'b0, 3'd0, 5'd0,  1'b0, 3'd0, 5'd0,  24'h000000, 1'b0, 1'b1, 1'b1, 1'b0, 24'h0000aa, 1'b0, 1'b1};
        tbl[6]  = '{1'b1, 3'd3, 5'd5,  1'b0, 3'd0, 5'd0,  24'h000000, 1'b0, 1'b0, 1'b0, 1'b1, 24'h123456, 1'b0, 1'b0};
        tbl[7]  = '{1'b1, 3'd3, 5'd6,  1'b0, 3'd0, 5'd0,  24'h000000, 1'b0, 1'b0, 1'b0, 1'b1, 24'hff0000, 1'b0, 1'b0};
        tbl[8]  = '{1'b0, 3'd0, 5'd0,  1'b1, 3'd3, 5'd6,  24'habcdef, 1'b0, 1'b0, 1'b1, 1'b0, 24'hff0000, 1'b0, 1'b0};
        tbl[9]  = '{1'b1, 3'd3, 5'd6,  1'b0, 3'd0, 5'd0,  24'h000000, 1'b0, 1'b0, 1'b0, 1'b1, 24'hff0000, 1'b0, 1'b0};
        tbl[10] = '{1'b0, 3'd0, 5'd0,  1'b0, 3'd0, 5'd0,  24'h000000, 1'b1, 1'b1, 1'b1, 1'b0, 24'hff0000, 1'b1, 1'b0};
        tbl[11] = '{1'b0, 3'd0, 5'd0,  1'b0, 3'd0, 5'd0,  24'h000000, 1'b0, 1'b0, 1'b1, 1'b0, 24'hff0000, 1'b1, 1'b0};
        tbl[12] = '{1'b1, 3'd3, 5'd6,  1'b0, 3'd0, 5'd0,  24'h000000, 1'b0, 1'b0, 1'b0, 1'b1, 24'hff0000, 1'b1, 1'b0};
        tbl[13] = '{1'b0, 3'd0, 5'd0,  1'b0, 3'd0, 5'd0,  24'h000000, 1'b0, 1'b1, 1'b1, 1'b0, 24'hff0000, 1'b0, 1'b1};
        tbl[14] = '{1'b1, 3'd3, 5'd6,  1'b0, 3'd0, 5'd0,  24'h000000, 1'b0, 1'b0, 1'b0, 1'b1, 24'habcdef, 1'b0, 1'b0};
        tbl[15] = '{1'b1, 3'd0, 5'd0,  1'b0, 3'd0, 5'd0,  24'h000000, 1'b0, 1'b0, 1'b0, 1'b1, 24'h0000aa, 1'b0, 1'b0};
        tbl[16] = '{1'b0, 3'd0, 5'd0,  1'b1, 3'd7, 5'd31, 24'h55aa55, 1'b0, 1'b0, 1'b1, 1'b0, 24'h0000aa, 1'b0, 1'b0};
        tbl[17] = '{1'b1, 3'd7, 5'd31, 1'b0, 3'd0, 5'd0,  24'h000000, 1'b0, 1'b0, 1'b0, 1'b1, 24'h0000aa, 1'b0, 1'b0};

        idle();
        s_idle();
        rst = 1'b1;
        tick();
        tick();
        chk1("rst_wr_ready", wr_ready, 1'b0);
        chk24("rst_pixel", pixel, 24'h0);
        chk1("rst_pixel_valid", pixel_valid, 1'b0);
        chk1("rst_swap_pending", swap_pending, 1'b0);
        chk1("rst_swap_done", swap_done, 1'b0);
        chk1("rst_busy", busy, 1'b0);
        rst = 1'b0;
        #1 chk1("idle_wr_ready", wr_ready, 1'b1);
        tick();

        // First clear fills bank 1, then becomes the front bank
        clear_req = 1'b1;
        clear_pixel = 24'hff0000;
        #1 chk1("clear_req_blocks_ready", wr_ready, 1'b0);
        tick();
        idle();
        chk1("clear_wr_ready", wr_ready, 1'b0);
        cnt = 0;
        while (busy && cnt < 400) begin
            cnt++;
            tick();
        end
        chkn("clear_busy_cycles", cnt, 256);

        swap_req = 1'b1;
        tick();
        swap_req = 1'b0;
        chk1("swap_pending_set", swap_pending, 1'b1);
        chk1("swap_done_early", swap_done, 1'b0);
        frame_complete = 1'b1;
        tick();
        frame_complete = 1'b0;
        chk1("swap_done", swap_done, 1'b1);
        chk1("swap_pending_clr", swap_pending, 1'b0);
        tick();
        chk1("swap_done_pulse", swap_done, 1'b0);

        for (int r = 0; r < 8; r++) begin
            for (int c = 0; c < 32; c++) begin
                rd_en = 1'b1;
                row = 3'(r);
                column = 5'(c);
                tick();
                chk1("clear_read_valid", pixel_valid, 1'b1);
                chk24("clear_read_pixel", pixel, 24'hff0000);
            end
        end
        idle();

        // Second clear into bank 0 with a 10-cycle read stall, an ignored
        // clear_req, and a swap request whose frame boundary falls inside the clear
        clear_req = 1'b1;
        clear_pixel = 24'h0000aa;
        tick();
        idle();
        cnt = 0;
        saw_done = 1'b0;
        while (busy && cnt < 400) begin
            rd_en = (cnt >= 100 && cnt < 110);
            clear_req = (cnt == 50);
            clear_pixel = (cnt == 50) ? 24'hbbbbbb : 24'h0;
            swap_req = (cnt == 60);
            frame_complete = (cnt == 80);
            tick();
            cnt++;
            if (swap_done) saw_done = 1'b1;
        end
        idle();
        chkn("clear_stall_cycles", cnt, 266);
        chk1("deferred_no_swap", saw_done, 1'b0);
        chk1("deferred_pending", swap_pending, 1'b1);
        frame_complete = 1'b1;
        tick();
        idle();
        chk1("deferred_swap_done", swap_done, 1'b1);
        chk1("deferred_pending_clr", swap_pending, 1'b0);

        rd_en = 1'b1;
        row = 3'd0; column = 5'd0;
        tick();
        chk24("bank0_first", pixel, 24'h0000aa);
        row = 3'd3; column = 5'd5;
        tick();
        chk24("bank0_mid", pixel, 24'h0000aa);
        row = 3'd7; column = 5'd31;
        tick();
        chk24("bank0_last", pixel, 24'h0000aa);
        idle();
        tick();

        for (int i = 0; i < 18; i++) begin
            rd_en = tbl[i].rd; row = tbl[i].row; column = tbl[i].col;
            wr_valid = tbl[i].wv; wr_row = tbl[i].wrow; wr_column = tbl[i].wcol;
            wr_pixel = tbl[i].wpix; swap_req = tbl[i].sreq; frame_complete = tbl[i].fc;
            #1 chk1($sformatf("vec%0d_wr_ready", i), wr_ready, tbl[i].e_ready);
            tick();
            chk1($sformatf("vec%0d_pixel_valid", i), pixel_valid, tbl[i].e_pv);
            chk24($sformatf("vec%0d_pixel", i), pixel, tbl[i].e_pix);
            chk1($sformatf("vec%0d_swap_pending", i), swap_pending, tbl[i].e_pend);
            chk1($sformatf("vec%0d_swap_done", i), swap_done, tbl[i].e_done);
        end
        idle();

        // Reset in the middle of a clear with a swap pending and bank 1 in front
        swap_req = 1'b1;
        tick();
        swap_req = 1'b0;
        frame_complete = 1'b1;
        tick();
        frame_complete = 1'b0;
        chk1("pre_rst_swap", swap_done, 1'b1);
        swap_req = 1'b1;
        tick();
        swap_req = 1'b0;
        chk1("pre_rst_pending", swap_pending, 1'b1);
        rd_en = 1'b1; row = 3'd7; column = 5'd31;
        tick();
        chk24("pre_rst_pixel", pixel, 24'h55aa55);
        idle();
        clear_req = 1'b1;
        clear_pixel = 24'hcccccc;
        tick();
        idle();
        for (int i = 0; i < 4; i++) tick();
        chk1("pre_rst_busy", busy, 1'b1);
        rst = 1'b1;
        #1 chk1("mid_rst_wr_ready", wr_ready, 1'b0);
        tick();
        rst = 1'b0;
        chk1("post_rst_busy", busy, 1'b0);
        chk1("post_rst_pending", swap_pending, 1'b0);
        chk1("post_rst_pixel_valid", pixel_valid, 1'b0);
        chk24("post_rst_pixel", pixel, 24'h0);
        tick();
        chk1("post_rst_still_idle", busy, 1'b0);
        rd_en = 1'b1; row = 3'd3; column = 5'd5;
        tick();
        idle();
        chk24("post_rst_front_bank0", pixel, 24'h0000aa);

        // Out-of-range host writes on the 6x6 instance
        s_creq = 1'b1;
        s_cpix = 24'h111111;
        tick();
        s_idle();
        cnt = 0;
        while (s_busy && cnt < 100) begin
            cnt++;
            tick();
        end
        chkn("s_clear_cycles", cnt, 36);
        s_sreq = 1'b1;
        tick();
        s_sreq = 1'b0;
        s_fc = 1'b1;
        tick();
        s_fc = 1'b0;
        chk1("s_swap_done", s_done, 1'b1);
        s_creq = 1'b1;
        s_cpix = 24'h222222;
        tick();
        s_idle();
        cnt = 0;
        while (s_busy && cnt < 100) begin
            cnt++;
            tick();
        end
        chkn("s_clear2_cycles", cnt, 36);

        s_wv = 1'b1; s_wrow = 3'd6; s_wcol = 3'd0; s_wpix = 24'hdead00;
        #1 chk1("s_oor_row_ready", s_wready, 1'b1);
        tick();
        s_wrow = 3'd0; s_wcol = 3'd7; s_wpix = 24'hbeef00;
        #1 chk1("s_oor_col_ready", s_wready, 1'b1);
        tick();
        s_wrow = 3'd1; s_wcol = 3'd2; s_wpix = 24'h333333;
        tick();
        s_idle();
        s_rd = 1'b1; s_row = 3'd0; s_col = 3'd0;
        tick();
        s_idle();
        chk24("s_oor_row_front_intact", s_pixel, 24'h111111);
        s_sreq = 1'b1;
        tick();
        s_sreq = 1'b0;
        s_fc = 1'b1;
        tick();
        s_fc = 1'b0;
        s_rd = 1'b1; s_row = 3'd1; s_col = 3'd1;
        tick();
        chk24("s_oor_col_back_intact", s_pixel, 24'h222222);
        s_row = 3'd1; s_col = 3'd2;
        tick();
        chk24("s_inrange_write", s_pixel, 24'h333333);
        s_idle();
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
